// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory access stage turning CU strobes into a req/ack memory transaction
// Optional REQ watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              clk_en,
    output logic              cpu_en,
    input  logic              IRWrite,
    input  logic              IorD,
    input  logic              MemtoWrite,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mdr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

    state_t      state, state_next;
    kind_t       kind;
    logic        we_q;
    logic        acc;
    logic        timeout_hit;
    logic [ADDR_W-1:0] addr_sel;

    assign acc      = IRWrite | IorD;
    assign addr_sel = IorD ? alu_out : pc;
    assign mem_req  = (state == REQ);
    assign mem_we   = we_q & (state == REQ);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] req_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive REQ cycle without ack.
    assign timeout_hit = (state == REQ) && !mem_ack && (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            req_cnt <= '0;
            mem_err <= 1'b0;
        end else begin
            if (state == REQ && !mem_ack) begin
                req_cnt <= req_cnt + 1'b1;
            end else begin
                req_cnt <= '0;
            end
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_en     = 1'b0;
        case (state)
            IDLE: begin
                cpu_en = clk_en & ~acc;
                if (acc && clk_en) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Holding here until clk_en keeps one transaction per CU access state.
                cpu_en = clk_en;
                if (clk_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            kind      <= K_FETCH;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            instr     <= '0;
            mdr       <= '0;
        end else begin
            if (state == IDLE && acc && clk_en) begin
                mem_addr  <= addr_sel & ~ADDR_W'(3);
                mem_wdata <= wdata;
                we_q      <= IorD & MemtoWrite;
                if (IorD) begin
                    kind <= MemtoWrite ? K_STORE : K_LOAD;
                end else begin
                    kind <= K_FETCH;
                end
            end
            // A timed-out fetch yields 0, which the CPU decodes as NOP.
            if (state == REQ && (mem_ack || timeout_hit)) begin
                case (kind)
                    K_FETCH: instr <= mem_ack ? mem_rdata : '0;
                    K_LOAD:  mdr   <= mem_ack ? mem_rdata : '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk_100M = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        cpu_en;
    logic        IRWrite = 1'b0;
    logic        IorD = 1'b0;
    logic        MemtoWrite = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] wdata = '0;
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] mdr;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    mem_access_ctrl #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_100M  (clk_100M),
        .rst       (rst),
        .clk_en    (clk_en),
        .cpu_en    (cpu_en),
        .IRWrite   (IRWrite),
        .IorD      (IorD),
        .MemtoWrite(MemtoWrite),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .instr     (instr),
        .mdr       (mdr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: request fields checked every REQ cycle, results checked on the completion pulse.
    initial begin
        logic prev_req = 1'b0;
        logic prev_rst = 1'b1;
        logic pending_done = 1'b0;
        done_t d;
        forever begin
            @(negedge clk_100M);
            if (mem_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    chk("req_addr", mem_addr, req_q[0].addr);
                    chk("req_we", {31'd0, mem_we}, {31'd0, req_q[0].we});
                    chk("req_wdata", mem_wdata, req_q[0].wdata);
                end
            end
            if (prev_req && !mem_req && req_q.size() > 0) begin
                void'(req_q.pop_front());
                if (!prev_rst) pending_done = 1'b1;
            end
            if (rst) pending_done = 1'b0;
            if (pending_done && cpu_en) begin
                pending_done = 1'b0;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    d = done_q.pop_front();
                    chk({d.name, "_instr"}, instr, d.instr);
                    chk({d.name, "_mdr"}, mdr, d.mdr);
                end
            end
            prev_req = mem_req;
            prev_rst = rst;
        end
    end

    // kind: 0 fetch, 1 load, 2 store, 3 load with IRWrite also high
    task automatic do_access(input string name, input int kind, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int ack_delay,
                             input int hold, input int exp_low, input logic [31:0] e_addr,
                             input logic [31:0] e_instr, input logic [31:0] e_mdr);
        int  low = 0;
        int  rq = 0;
        int  held = 0;
        bit  seen = 0;
        logic ack_n;
        logic clk_n;
        bit  next_req;
        req_t  r;
        done_t d;
        r.addr = e_addr; r.we = (kind == 2); r.wdata = wd;
        d.name = name; d.instr = e_instr; d.mdr = e_mdr;
        req_q.push_back(r);
        done_q.push_back(d);
        @(posedge clk_100M); #1;
        IRWrite    = (kind == 0 || kind == 3);
        IorD       = (kind != 0);
        MemtoWrite = (kind == 2);
        pc         = (kind == 0) ? addr : ~addr;
        alu_out    = (kind == 0) ? ~addr : addr;
        wdata      = wd;
        mem_rdata  = rd;
        clk_en     = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_100M);
            if (cpu_en) begin
                seen = 1;
                break;
            end
            low++;
            clk_n = clk_en;
            if (mem_req) rq++;
            next_req = (c == 0) || (mem_req && rq != ack_delay);
            ack_n = next_req && (rq + 1 == ack_delay);
            if (ack_n && hold > 0) clk_n = 1'b0;
            if (!mem_req && c > 0) begin
                held++;
                if (held >= hold) clk_n = 1'b1;
            end
            @(posedge clk_100M); #1;
            mem_ack = ack_n;
            clk_en  = clk_n;
            if (rq == 1) begin
                pc      = 32'hDEAD_BEEF;
                alu_out = 32'hFEED_FACE;
                wdata   = 32'h0BAD_0BAD;
            end
        end
        chk({name, "_cpu_en_seen"}, {31'd0, seen}, 32'd1);
        chk({name, "_stall_cycles"}, low, exp_low);
        @(posedge clk_100M); #1;
        IRWrite = 1'b0; IorD = 1'b0; MemtoWrite = 1'b0; mem_ack = 1'b0; clk_en = 1'b1;
    endtask

    initial begin
        // Reset with a stale ack present
        rst = 1'b1; mem_ack = 1'b1;
        repeat (3) @(posedge clk_100M);
        @(negedge clk_100M);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_mdr", mdr, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd1);
        @(posedge clk_100M); #1;
        rst = 1'b0; mem_ack = 1'b0;

        do_access("fetch", 0, 32'h0000_0010, 32'h0, 32'h2008_0005, 3, 0, 4,
                  32'h0000_0010, 32'h2008_0005, 32'h0);
        do_access("load", 1, 32'h0000_0107, 32'h0, 32'hCAFE_F00D, 1, 0, 2,
                  32'h0000_0104, 32'h2008_0005, 32'hCAFE_F00D);
        do_access("store", 2, 32'h0000_0203, 32'h1234_5678, 32'hFFFF_FFFF, 2, 0, 3,
                  32'h0000_0200, 32'h2008_0005, 32'hCAFE_F00D);
        do_access("prio", 3, 32'h0000_0302, 32'h0, 32'h0BAD_CAFE, 2, 0, 3,
                  32'h0000_0300, 32'h2008_0005, 32'h0BAD_CAFE);
        do_access("hold", 0, 32'h0000_0020, 32'h0, 32'h1111_1111, 1, 5, 7,
                  32'h0000_0020, 32'h1111_1111, 32'h0BAD_CAFE);

        // Idle: no further request, spurious ack ignored
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_100M);
            chk("idle_no_req", {31'd0, mem_req}, 32'd0);
            chk("idle_cpu_en", {31'd0, cpu_en}, 32'd1);
        end
        chk("idle_instr_kept", instr, 32'h1111_1111);
        @(posedge clk_100M); #1;
        mem_ack = 1'b0;

        // Access requested while clk_en is low: no request, CPU stalled
        IRWrite = 1'b1; pc = 32'h0000_0030; clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_100M);
            chk("noclk_no_req", {31'd0, mem_req}, 32'd0);
            chk("noclk_cpu_en", {31'd0, cpu_en}, 32'd0);
        end
        @(posedge clk_100M); #1;
        IRWrite = 1'b0; clk_en = 1'b1;

        // Reset during the second REQ cycle, ack arrives one cycle later
        begin
            req_t r;
            r.addr = 32'h0000_0040; r.we = 1'b0; r.wdata = 32'h0;
            req_q.push_back(r);
        end
        @(posedge clk_100M); #1;
        IRWrite = 1'b1; pc = 32'h0000_0040; wdata = 32'h0;
        @(negedge clk_100M);
        @(posedge clk_100M); #1;
        IRWrite = 1'b0;
        @(negedge clk_100M);
        chk("abort_req1", {31'd0, mem_req}, 32'd1);
        @(posedge clk_100M); #1;
        rst = 1'b1;
        @(negedge clk_100M);
        @(posedge clk_100M); #1;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk_100M);
        chk("abort_req_dropped", {31'd0, mem_req}, 32'd0);
        chk("abort_instr", instr, 32'd0);
        chk("abort_mdr", mdr, 32'd0);
        chk("abort_cpu_en", {31'd0, cpu_en}, 32'd1);
        @(posedge clk_100M); #1;
        mem_ack = 1'b0;
        @(negedge clk_100M);
        chk("abort_stale_ack_req", {31'd0, mem_req}, 32'd0);
        chk("abort_stale_ack_instr", instr, 32'd0);

`ifdef MEM_TIMEOUT_EN
        do_access("timeout", 0, 32'h0000_0050, 32'h0, 32'h9999_9999, 0, 0, 5,
                  32'h0000_0050, 32'h0, 32'h0);
        chk("timeout_err", {31'd0, mem_err}, 32'd1);
        do_access("after_timeout", 0, 32'h0000_0054, 32'h0, 32'hA5A5_A5A5, 2, 0, 3,
                  32'h0000_0054, 32'hA5A5_A5A5, 32'h0);
        chk("err_sticky", {31'd0, mem_err}, 32'd1);
`else
        chk("err_tied_low", {31'd0, mem_err}, 32'd0);
`endif

        repeat (3) @(negedge clk_100M);
        chk("req_q_drained", req_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
